// File: rtl/axi_rd_arb.sv
// axi_rd_arb: two-master AXI read arbiter, registered AR toward the slave, R routed by grant.
// Define AXI_RD_ARB_FIXED_PRI_EN for fixed priority (master 0 wins ties).
module axi_rd_arb #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*ID_W-1:0]   s_arid,
  input  logic [2*ADDR_W-1:0] s_araddr,
  input  logic [15:0]         s_arlen,
  input  logic [5:0]          s_arsize,
  input  logic [3:0]          s_arburst,
  input  logic [1:0]          s_arvalid,
  output logic [1:0]          s_arready,
  output logic [2*ID_W-1:0]   s_rid,
  output logic [2*DATA_W-1:0] s_rdata,
  output logic [3:0]          s_rresp,
  output logic [1:0]          s_rlast,
  output logic [1:0]          s_rvalid,
  input  logic [1:0]          s_rready,
  output logic [ID_W-1:0]     m_arid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [ID_W-1:0]     m_rid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, AR, DATA} state_t;

  state_t state, state_nx;
  logic   gnt;
  logic   win;
  logic   req_any;
  logic   burst_done;

  assign req_any = |s_arvalid;

`ifdef AXI_RD_ARB_FIXED_PRI_EN
  assign win = ~s_arvalid[0];
`else
  logic prio;

  // Tie goes to the pointer; a lone requester wins outright.
  assign win = (&s_arvalid) ? prio : ~s_arvalid[0];

  always_ff @(posedge clk) begin
    if (rst) prio <= 1'b0;
    else if (burst_done) prio <= ~gnt;
  end
`endif

  assign m_rready   = (state == DATA) &
                      (gnt ? s_rready[1] : s_rready[0]);
  assign burst_done = m_rvalid & m_rready & m_rlast;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx  = state;
    s_arready = '0;
    unique case (state)
      IDLE: begin
        if (req_any) begin
          state_nx       = AR;
          s_arready[win] = 1'b1;
        end
      end
      AR:      if (m_arready)  state_nx = DATA;
      DATA:    if (burst_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_any) begin
        gnt       <= win;
        m_arvalid <= 1'b1;
        m_arid    <= win ? s_arid[ID_W +: ID_W]
                         : s_arid[0 +: ID_W];
        m_araddr  <= win ? s_araddr[ADDR_W +: ADDR_W]
                         : s_araddr[0 +: ADDR_W];
        m_arlen   <= win ? s_arlen[15:8] : s_arlen[7:0];
        m_arsize  <= win ? s_arsize[5:3] : s_arsize[2:0];
        m_arburst <= win ? s_arburst[3:2] : s_arburst[1:0];
      end else if (state == AR && m_arready) begin
        m_arvalid <= 1'b0;
      end
    end
  end

  // Non-granted master sees an all-zero R channel.
  always_comb begin
    s_rid    = '0;
    s_rdata  = '0;
    s_rresp  = '0;
    s_rlast  = '0;
    s_rvalid = '0;
    for (int i = 0; i < 2; i++) begin
      if (state == DATA && gnt == i[0]) begin
        s_rid[i*ID_W +: ID_W]       = m_rid;
        s_rdata[i*DATA_W +: DATA_W] = m_rdata;
        s_rresp[i*2 +: 2]           = m_rresp;
        s_rlast[i]                  = m_rlast;
        s_rvalid[i]                 = m_rvalid;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arb.sv
// tb_axi_rd_arb: random masters/slave against a transaction-level arbiter model.
// Honours AXI_RD_ARB_FIXED_PRI_EN when the design is built with it.
module tb_axi_rd_arb;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NCYC   = 3000;

  logic                clk = 1'b0;
  logic                rst;
  logic [2*ID_W-1:0]   s_arid;
  logic [2*ADDR_W-1:0] s_araddr;
  logic [15:0]         s_arlen;
  logic [5:0]          s_arsize;
  logic [3:0]          s_arburst;
  logic [1:0]          s_arvalid;
  logic [1:0]          s_arready;
  logic [2*ID_W-1:0]   s_rid;
  logic [2*DATA_W-1:0] s_rdata;
  logic [3:0]          s_rresp;
  logic [1:0]          s_rlast;
  logic [1:0]          s_rvalid;
  logic [1:0]          s_rready;
  logic [ID_W-1:0]     m_arid;
  logic [ADDR_W-1:0]   m_araddr;
  logic [7:0]          m_arlen;
  logic [2:0]          m_arsize;
  logic [1:0]          m_arburst;
  logic                m_arvalid;
  logic                m_arready;
  logic [ID_W-1:0]     m_rid;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rlast;
  logic                m_rvalid;
  logic                m_rready;
  logic                busy;

  always #5 clk = ~clk;

  axi_rd_arb #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy)
  );

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } req_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Ties go to the preferred master; a lone requester always wins.
  function automatic int pick(input logic [1:0] v, input int p);
    if (v == 2'b11) return p;
    return v[0] ? 0 : 1;
  endfunction

  req_t cur;
  req_t req [2];
  bit   pend [2];
  int   ph;
  int   own;
  int   pref;
  int   w;
  int   sl_left;
  int   nbeat;
  int   nrst;
  bit   sl_active;
  bit   rhold;
  bit   just_rst;
  bit   force_m1;
  bit   gen;
  logic [1:0] exp_rdy;

  initial begin
    rst = 1'b1;
    s_arvalid = '0; s_arid = '0; s_araddr = '0; s_arlen = '0;
    s_arsize = '0; s_arburst = '0; s_rready = '0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0;
    m_rlast = 1'b0; m_rvalid = 1'b0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0;
      req[m]  = '{default: '0};
    end
    cur = '{default: '0};
    ph = 0; own = 0; pref = 0; sl_left = 0; nbeat = 0; nrst = 0;
    sl_active = 0; rhold = 0; just_rst = 1; force_m1 = 0;
    repeat (3) @(posedge clk);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      gen = (c >= 10);
      rst = gen && ph == 2 && nrst < 6 && cur.len >= 3 &&
            (int'(cur.len) + 1 - sl_left) == 2 &&
            $urandom_range(0, 1) == 0;

      for (int m = 0; m < 2; m++) begin
        if (gen && !pend[m] &&
            (c == 10 || $urandom_range(0, 3) == 0)) begin
          req[m].id    = ID_W'($urandom);
          req[m].addr  = $urandom;
          req[m].len   = 8'($urandom_range(0, 9));
          req[m].size  = 3'($urandom);
          req[m].burst = 2'($urandom);
          pend[m]      = 1'b1;
        end
      end
      if (force_m1 && gen && !pend[1]) begin
        req[1].id    = ID_W'(5);
        req[1].addr  = $urandom;
        req[1].len   = 8'($urandom_range(0, 4));
        req[1].size  = 3'd2;
        req[1].burst = 2'd1;
        pend[1]      = 1'b1;
        force_m1     = 1'b0;
      end
      s_arvalid = {pend[1], pend[0]};
      s_arid    = {req[1].id, req[0].id};
      s_araddr  = {req[1].addr, req[0].addr};
      s_arlen   = {req[1].len, req[0].len};
      s_arsize  = {req[1].size, req[0].size};
      s_arburst = {req[1].burst, req[0].burst};
      for (int m = 0; m < 2; m++)
        s_rready[m] = ($urandom_range(0, 3) != 0);
      m_arready = ($urandom_range(0, 2) == 0);

      if (!rhold) begin
        m_rdata = $urandom;
        m_rresp = 2'($urandom);
        if (sl_active) begin
          m_rvalid = ($urandom_range(0, 3) != 0);
          m_rid    = cur.id;
          m_rlast  = (sl_left == 1);
        end else begin
          m_rvalid = ($urandom_range(0, 4) == 0);
          m_rid    = ID_W'($urandom);
          m_rlast  = 1'($urandom);
        end
      end

      @(negedge clk);
      exp_rdy = '0;
      if (ph == 0 && s_arvalid != 2'b00) begin
        w = pick(s_arvalid, pref);
        exp_rdy[w] = 1'b1;
      end
      chk("s_arready", s_arready, exp_rdy);
      chk("busy", busy, ph != 0);
      chk("m_arvalid", m_arvalid, ph == 1);
      if (just_rst) begin
        chk("rst_m_arid", m_arid, 0);
        chk("rst_m_araddr", m_araddr, 0);
        chk("rst_m_arlen", m_arlen, 0);
      end
      if (ph == 1) begin
        chk("m_arid", m_arid, cur.id);
        chk("m_araddr", m_araddr, cur.addr);
        chk("m_arlen", m_arlen, cur.len);
        chk("m_arsize", m_arsize, cur.size);
        chk("m_arburst", m_arburst, cur.burst);
      end
      chk("m_rready", m_rready, ph == 2 && s_rready[own]);
      for (int m = 0; m < 2; m++) begin
        bit dv;
        dv = (ph == 2 && own == m);
        chk($sformatf("s_rvalid%0d", m), s_rvalid[m], dv ? m_rvalid : 1'b0);
        chk($sformatf("s_rlast%0d", m), s_rlast[m], dv ? m_rlast : 1'b0);
        chk($sformatf("s_rdata%0d", m), s_rdata[m*DATA_W +: DATA_W],
            dv ? m_rdata : '0);
        chk($sformatf("s_rid%0d", m), s_rid[m*ID_W +: ID_W],
            dv ? m_rid : '0);
        chk($sformatf("s_rresp%0d", m), s_rresp[m*2 +: 2],
            dv ? m_rresp : 2'b00);
      end

      if (rst) begin
        ph = 0; pref = 0; sl_active = 0; rhold = 0; nbeat = 0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        just_rst = 1; force_m1 = 1; nrst++;
      end else begin
        just_rst = 0;
        case (ph)
          0: begin
            if (s_arvalid != 2'b00) begin
              w = pick(s_arvalid, pref);
              cur = req[w]; own = w; pend[w] = 1'b0; ph = 1;
            end
          end
          1: begin
            if (m_arready) begin
              ph = 2; sl_active = 1; rhold = 0; nbeat = 0;
              sl_left = int'(cur.len) + 1;
            end
          end
          default: begin
            if (s_rvalid[own] && s_rready[own]) nbeat++;
            if (m_rvalid && s_rready[own]) begin
              sl_left--;
              rhold = 0;
              if (m_rlast) begin
                chk("beats", nbeat, int'(cur.len) + 1);
                ph = 0; sl_active = 0;
`ifndef AXI_RD_ARB_FIXED_PRI_EN
                pref = 1 - own;
`endif
              end
            end else if (m_rvalid) begin
              rhold = 1;
            end
          end
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rd_arb.md
Name: axi_rd_arb

Overview:
- Two-master to one-slave AXI read-channel arbiter (AR + R channels).
- Sits between up to two axi_mst-style read masters and a single axi_slv-style read slave.
- Grants one master at a time and registers its AR request toward the slave.
- Routes the R burst back to the granted master; the grant is held until the RLAST handshake (one outstanding burst).

Parameters:
ID_W, 4, AXI ID width
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
s_arid  in  2*ID_W  master-side ARID; master i at bits [i*ID_W +: ID_W]
s_araddr  in  2*ADDR_W  master-side ARADDR, packed as above
s_arlen  in  2*8  master-side ARLEN
s_arsize  in  2*3  master-side ARSIZE
s_arburst  in  2*2  master-side ARBURST
s_arvalid  in  2  per-master ARVALID
s_arready  out  2  per-master ARREADY
s_rid  out  2*ID_W  per-master RID
s_rdata  out  2*DATA_W  per-master RDATA
s_rresp  out  2*2  per-master RRESP
s_rlast  out  2  per-master RLAST
s_rvalid  out  2  per-master RVALID
s_rready  in  2  per-master RREADY
m_arid  out  ID_W  slave-side ARID (registered)
m_araddr  out  ADDR_W  slave-side ARADDR (registered)
m_arlen  out  8  slave-side ARLEN (registered)
m_arsize  out  3  slave-side ARSIZE (registered)
m_arburst  out  2  slave-side ARBURST (registered)
m_arvalid  out  1  slave-side ARVALID (registered)
m_arready  in  1  slave-side ARREADY
m_rid  in  ID_W  slave RID
m_rdata  in  DATA_W  slave RDATA
m_rresp  in  2  slave RRESP
m_rlast  in  1  slave RLAST
m_rvalid  in  1  slave RVALID
m_rready  out  1  slave RREADY
busy  out  1  high while in AR or DATA state

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, gnt=0, prio pointer=master 0.
  - m_arvalid=0 and all m_ar* regs=0.
  - busy=0, s_arready=0, s_rvalid=0, m_rready=0.
- FSM states: IDLE, AR, DATA.
- IDLE:
  - Arbitrate over s_arvalid using round-robin; the prio pointer names the preferred master.
  - If any request: s_arready[win]=1 combinationally in the same cycle (the master AR handshake completes).
  - Next edge: latch win's AR fields into m_ar*, set m_arvalid=1, gnt=win, go to AR.
  - The loser's s_arready stays 0; its request remains pending (AXI: valid must not drop).
- AR:
  - Hold m_ar* stable with m_arvalid=1 until m_arready.
  - On m_arvalid&m_arready: m_arvalid<=0, go to DATA.
  - s_arready=0 for both masters.
- DATA:
  - s_r*[gnt] = m_r* combinationally; m_rready = s_rready[gnt].
  - The non-granted master sees s_rvalid=0, s_rlast=0, data/id/resp=0.
  - m_rready=0 outside DATA.
  - On m_rvalid&m_rready&m_rlast: go to IDLE; prio pointer <= ~gnt.
- Latency:
  - Master AR handshake (cycle N) gives m_arvalid at N+1.
  - Minimum AR-to-AR spacing for back-to-back bursts = burst beats + 2 cycles (IDLE re-arbitration cycle included).
- RID is forwarded unmodified; routing uses the gnt register, never the ID.
- Simultaneous requests in IDLE: the prio-pointer master wins.
  - After a burst completes, the other master is preferred.
  - A lone requester always wins regardless of pointer.
- Single-beat burst (arlen=0): first beat carries rlast; return to IDLE after one R handshake.
- RVALID backpressure (s_rready=0) stalls the slave transparently; no buffering.
- R beats arriving in AR state are not accepted (m_rready=0).
- Reset mid-burst:
  - The FSM aborts to IDLE and m_arvalid drops the next edge.
  - Upstream/downstream must be reset together; no recovery of the in-flight burst.

Optional Feature:
- Macro AXI_RD_ARB_FIXED_PRI_EN.
  - Defined: fixed priority, master 0 always wins simultaneous requests; the prio pointer logic is removed.
  - Undefined: round-robin as in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle, no s_arvalid -> m_arvalid=0, busy=0, s_arready=0, m_rready=0 for 10 cycles.
- M0 only, araddr=0x100, arlen=3 -> s_arready[0] pulses 1 cycle; next cycle m_araddr=0x100, m_arlen=3, m_arvalid=1. Four beats delivered only to master 0; last beat has s_rlast[0]=1; then IDLE.
- Both masters request at cycle after reset -> M0 granted first.
  - Round-robin build: M1 granted after M0's rlast.
  - FIXED_PRI build: M0 granted again if it re-requests immediately.
- Slave holds m_arready=0 for 5 cycles -> m_ar* stable, m_arvalid held, no s_arready pulses.
- Granted master drops s_rready for 3 cycles mid-burst -> m_rready=0 for those cycles; beat data unchanged and delivered after; beat count = arlen+1.
- Assert rst during DATA beat 2 of an 8-beat burst -> next edge state=IDLE, m_rready=0, s_rvalid=0; after release, a new M1 request with arid=5 yields m_arid=5.
